// File: rtl/trigger_capture_pkg.sv
// Shared types and default sizes for the trigger capture block.
package trigger_capture_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/trigger_capture_if.sv
// Event-source / snapshot-consumer bundle for trigger_capture.
interface trigger_capture_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] trig_in;
  logic [WIDTH-1:0] trig_mask;
  logic             snap_req;
  logic             snap_ack;
  logic             snap_valid;
  logic [WIDTH-1:0] snap_flags;
  logic [WIDTH-1:0] snap_overrun;
  logic [CNT_W-1:0] snap_count;
  logic             pending;

  modport master (
    output trig_in, trig_mask, snap_req, snap_ack,
    input  snap_valid, snap_flags, snap_overrun, snap_count, pending
  );

  modport slave (
    input  trig_in, trig_mask, snap_req, snap_ack,
    output snap_valid, snap_flags, snap_overrun, snap_count, pending
  );
endinterface

// File: rtl/trigger_capture_sat_counter.sv
// Saturating up-counter with synchronous load; never wraps past all-ones.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr_load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Load takes priority so a clear never misses the increment it carries in load_val.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr_load) begin
      cnt <= load_val;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/trigger_capture.sv
// Sticky capture of one-cycle trigger pulses with an atomic snapshot-and-clear
// handshake for host polling.
module trigger_capture
  import trigger_capture_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               sys_clk,
  input  logic               reset,
  trigger_capture_if.slave   bus
);
  state_t           state;
  logic [WIDTH-1:0] ev;
  logic             any_ev;
  logic             snap_take;
  logic [WIDTH-1:0] flags;
  logic [WIDTH-1:0] overrun;
  logic [WIDTH-1:0] flags_nxt;
  logic [WIDTH-1:0] overrun_nxt;
  logic [CNT_W-1:0] live_cnt;
  logic             pending_r;
  logic             snap_valid_r;
  logic [WIDTH-1:0] snap_flags_r;
  logic [WIDTH-1:0] snap_overrun_r;
  logic [CNT_W-1:0] snap_count_r;

  assign ev        = bus.trig_in & bus.trig_mask;
  assign any_ev    = |ev;
  assign snap_take = (state == ST_IDLE) && bus.snap_req;

  // On a snapshot edge the live set restarts with only this cycle's events, so
  // nothing is lost between the copy and the clear.
  always_comb begin
    flags_nxt   = flags | ev;
    overrun_nxt = overrun | (ev & flags);
    if (snap_take) begin
      flags_nxt   = ev;
      overrun_nxt = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      flags     <= '0;
      overrun   <= '0;
      pending_r <= 1'b0;
    end else begin
      flags     <= flags_nxt;
      overrun   <= overrun_nxt;
      pending_r <= |flags_nxt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_live_cnt (
    .clk      (sys_clk),
    .rst      (reset),
    .inc      (any_ev),
    .clr_load (snap_take),
    .load_val ({{(CNT_W-1){1'b0}}, any_ev}),
    .cnt      (live_cnt)
  );

  // Snapshot handshake; ack wins over a simultaneous request while holding.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      snap_valid_r   <= 1'b0;
      snap_flags_r   <= '0;
      snap_overrun_r <= '0;
      snap_count_r   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.snap_req) begin
            state          <= ST_HOLD;
            snap_valid_r   <= 1'b1;
            snap_flags_r   <= flags;
            snap_overrun_r <= overrun;
            snap_count_r   <= live_cnt;
          end
        end
        ST_HOLD: begin
          if (bus.snap_ack) begin
            state        <= ST_IDLE;
            snap_valid_r <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          snap_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.snap_valid   = snap_valid_r;
  assign bus.snap_flags   = snap_flags_r;
  assign bus.snap_overrun = snap_overrun_r;
  assign bus.snap_count   = snap_count_r;
  assign bus.pending      = pending_r;
endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture: sticky flags, overrun, saturation,
// snapshot handshake and reset abort.
module tb_trigger_capture;
  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  int   n_chk   = 0;
  int   n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  trigger_capture_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  trigger_capture #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle, let the edge happen, sample 1ns later.
  task automatic cyc(input logic [31:0] trig, input logic req, input logic ack);
    bus.trig_in  = trig;
    bus.snap_req = req;
    bus.snap_ack = ack;
    @(posedge sys_clk);
    #1;
    bus.trig_in  = '0;
    bus.snap_req = 1'b0;
    bus.snap_ack = 1'b0;
  endtask

  task automatic chk_snap(input string tag, input logic [31:0] fl,
                          input logic [31:0] ov, input logic [31:0] cn);
    chk({tag, "_valid"},   32'(bus.snap_valid), 32'h1);
    chk({tag, "_flags"},   bus.snap_flags,      fl);
    chk({tag, "_overrun"}, bus.snap_overrun,    ov);
    chk({tag, "_count"},   32'(bus.snap_count), cn);
  endtask

  initial begin
    bus.trig_in   = '0;
    bus.trig_mask = '1;
    bus.snap_req  = 1'b0;
    bus.snap_ack  = 1'b0;

    // Reset state
    reset = 1'b1;
    cyc(32'h0, 1'b0, 1'b0);
    cyc(32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    chk("rst_valid",   32'(bus.snap_valid), 32'h0);
    chk("rst_pending", 32'(bus.pending),    32'h0);
    chk("rst_flags",   bus.snap_flags,      32'h0);
    chk("rst_count",   32'(bus.snap_count), 32'h0);

    // Ack while idle does nothing
    cyc(32'h0, 1'b0, 1'b1);
    chk("idle_ack_valid", 32'(bus.snap_valid), 32'h0);

    // Test 1: bits 0 and 5 once each
    cyc(32'h01, 1'b0, 1'b0);
    cyc(32'h20, 1'b0, 1'b0);
    cyc(32'h00, 1'b0, 1'b0);
    chk("t1_pending_set", 32'(bus.pending), 32'h1);
    chk("t1_pre_valid",   32'(bus.snap_valid), 32'h0);
    cyc(32'h0, 1'b1, 1'b0);
    chk_snap("t1", 32'h21, 32'h0, 32'd2);
    cyc(32'h0, 1'b0, 1'b0);
    chk("t1_pending_clr", 32'(bus.pending), 32'h0);
    cyc(32'h0, 1'b0, 1'b1);
    chk("t1_ack_valid", 32'(bus.snap_valid), 32'h0);

    // Test 2: bit 3 three times, bit 7 masked while pulsing
    bus.trig_mask = ~32'h80;
    cyc(32'h88, 1'b0, 1'b0);
    cyc(32'h88, 1'b0, 1'b0);
    cyc(32'h88, 1'b0, 1'b0);
    cyc(32'h0, 1'b1, 1'b0);
    chk_snap("t2", 32'h08, 32'h08, 32'd3);
    cyc(32'h0, 1'b0, 1'b1);
    bus.trig_mask = '1;

    // Test 3: pulse coinciding with the snapshot goes to the next period
    cyc(32'h10, 1'b0, 1'b0);
    cyc(32'h02, 1'b1, 1'b0);
    chk_snap("t3a", 32'h10, 32'h0, 32'd1);
    cyc(32'h0, 1'b0, 1'b1);
    cyc(32'h0, 1'b1, 1'b0);
    chk_snap("t3b", 32'h02, 32'h0, 32'd1);
    cyc(32'h0, 1'b0, 1'b1);

    // Mask change does not clear an existing flag; masked pulse is not an overrun
    cyc(32'h200, 1'b0, 1'b0);
    bus.trig_mask = '0;
    cyc(32'h200, 1'b0, 1'b0);
    bus.trig_mask = '1;
    cyc(32'h0, 1'b1, 1'b0);
    chk_snap("mask", 32'h200, 32'h0, 32'd1);
    cyc(32'h0, 1'b0, 1'b1);

    // Test 4: saturation after 300 pulse cycles
    for (int i = 0; i < 300; i++) cyc(32'h04, 1'b0, 1'b0);
    cyc(32'h0, 1'b1, 1'b0);
    chk_snap("t4", 32'h04, 32'h04, 32'd255);
    cyc(32'h01, 1'b1, 1'b0);
    chk_snap("t4_hold_req", 32'h04, 32'h04, 32'd255);
    cyc(32'h01, 1'b1, 1'b1);
    chk("t4_reqack_valid", 32'(bus.snap_valid), 32'h0);
    chk("t4_reqack_flags", bus.snap_flags, 32'h04);
    cyc(32'h0, 1'b1, 1'b0);
    chk_snap("t4_retry", 32'h01, 32'h01, 32'd2);
    cyc(32'h0, 1'b0, 1'b1);

    // Test 5: reset aborts a held snapshot
    cyc(32'h08, 1'b0, 1'b0);
    cyc(32'h0, 1'b1, 1'b0);
    chk_snap("t5_pre", 32'h08, 32'h0, 32'd1);
    cyc(32'h40, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    chk("t5_valid",   32'(bus.snap_valid),   32'h0);
    chk("t5_flags",   bus.snap_flags,        32'h0);
    chk("t5_overrun", bus.snap_overrun,      32'h0);
    chk("t5_count",   32'(bus.snap_count),   32'h0);
    chk("t5_pending", 32'(bus.pending),      32'h0);
    cyc(32'h0, 1'b1, 1'b0);
    chk_snap("t5_idle", 32'h0, 32'h0, 32'd0);
    cyc(32'h0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
